digit_vote_filter: RTL and testbench

DIGIT_VOTE_FILTER -- requirements
Module: digit_vote_filter

---
 rtl/digit_vote_pkg.sv | 29 ++
 rtl/vote_history.sv | 70 +++++++
 rtl/digit_vote_filter.sv | 255 +++++++++++++++++++++++++
 tb/tb_digit_vote_filter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/digit_vote_pkg.sv
// rtl/digit_vote_pkg.sv - shared types and constants for the digit vote filter
//
// Purpose: FSM state encoding, class/width constants, LED bit positions and
//          a digit range helper used by digit_vote_filter and vote_history.
// Ports:   none (package).
package digit_vote_pkg;

    localparam int NUM_CLASSES = 10;
    localparam int DIGIT_W     = 4;
    localparam int CNT_W       = 5;

    localparam int LED_VALID_BIT  = 4;
    localparam int LED_STALE_BIT  = 5;
    localparam int LED_BUSY_BIT   = 6;
    localparam int LED_ENABLE_BIT = 7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INSERT,
        ST_ACCUM,
        ST_SELECT,
        ST_COMMIT
    } state_t;

    function automatic logic is_valid_digit(input logic [DIGIT_W-1:0] d);
        return d < DIGIT_W'(NUM_CLASSES);
    endfunction

endpackage

// File: rtl/vote_history.sv
// rtl/vote_history.sv - shift register of past classification results
//
// Purpose: holds the last HIST_DEPTH digits with a valid bit per slot. A shift
//          pushes a new digit into slot 0 and discards the oldest slot.
// Ports:   clk, rst_n      clock, asynchronous active-low reset
//          clear           invalidate every slot (wins over shift)
//          shift_en        push shift_digit into slot 0
//          shift_digit     digit to push
//          rd_idx          slot index for the read port
//          rd_digit        digit stored at rd_idx
//          rd_valid        slot rd_idx holds a result
module vote_history
    import digit_vote_pkg::*;
#(
    parameter int HIST_DEPTH = 8,
    parameter int IDX_W      = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               shift_en,
    input  logic [DIGIT_W-1:0] shift_digit,
    input  logic [IDX_W-1:0]   rd_idx,
    output logic [DIGIT_W-1:0] rd_digit,
    output logic               rd_valid
);

    logic [DIGIT_W-1:0]    digit_q [HIST_DEPTH];
    logic [DIGIT_W-1:0]    digit_d [HIST_DEPTH];
    logic [HIST_DEPTH-1:0] valid_q;
    logic [HIST_DEPTH-1:0] valid_d;

    always_comb begin
        digit_d = digit_q;
        valid_d = valid_q;
        if (clear) begin
            valid_d = '0;
        end else if (shift_en) begin
            digit_d[0] = shift_digit;
            valid_d[0] = 1'b1;
            for (int i = 1; i < HIST_DEPTH; i++) begin
                digit_d[i] = digit_q[i-1];
                valid_d[i] = valid_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < HIST_DEPTH; i++) begin
                digit_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            digit_q <= digit_d;
        end
    end

    // Guard the read so a non-power-of-two depth never indexes past the end.
    always_comb begin
        rd_digit = '0;
        rd_valid = 1'b0;
        if (int'(rd_idx) < HIST_DEPTH) begin
            rd_digit = digit_q[rd_idx];
            rd_valid = valid_q[rd_idx];
        end
    end

endmodule

// File: rtl/digit_vote_filter.sv
// rtl/digit_vote_filter.sv - majority vote filter over recent lenet results
//
// Purpose: captures lenet results on rising ready edges, keeps a history of
//          the last HIST_DEPTH digits, and publishes the most frequent digit
//          once it reaches MIN_VOTES. Results go stale after TIMEOUT_CYC idle
//          cycles.
// Ports:   clk, rst_n      clock, asynchronous active-low reset
//          lenet_ready     result ready level (rising edge = new result)
//          lenet_digit     classification, sampled on the rising edge
//          enable          accept new results
//          clear           flush history, pending result and stable output
//          stable_digit    voted digit
//          stable_valid    stable_digit has enough votes and is not stale
//          new_result      pulse when the published digit changes or validates
//          vote_count      vote total of the last winner
//          dropped         pulse when a pending result is overwritten
//          LED             {enable, busy, stale, stable_valid, stable_digit}
module digit_vote_filter
    import digit_vote_pkg::*;
#(
    parameter int HIST_DEPTH  = 8,
    parameter int MIN_VOTES   = 5,
    parameter int TIMEOUT_CYC = 100_000_000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               lenet_ready,
    input  logic [DIGIT_W-1:0] lenet_digit,
    input  logic               enable,
    input  logic               clear,
    output logic [DIGIT_W-1:0] stable_digit,
    output logic               stable_valid,
    output logic               new_result,
    output logic [CNT_W-1:0]   vote_count,
    output logic               dropped,
    output logic [7:0]         LED
);

    localparam int IDX_W = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1;
    localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TIMEOUT_V = TO_W'(TIMEOUT_CYC);

    state_t             state_q, state_d;
    logic               ready_prev_q, ready_prev_d;
    logic               pending_q, pending_d;
    logic [DIGIT_W-1:0] pending_digit_q, pending_digit_d;
    logic [IDX_W-1:0]   acc_idx_q, acc_idx_d;
    logic [DIGIT_W-1:0] sel_idx_q, sel_idx_d;
    logic [CNT_W-1:0]   counts_q [NUM_CLASSES];
    logic [CNT_W-1:0]   counts_d [NUM_CLASSES];
    logic [DIGIT_W-1:0] winner_q, winner_d;
    logic [CNT_W-1:0]   win_cnt_q, win_cnt_d;
    logic [DIGIT_W-1:0] stable_digit_q, stable_digit_d;
    logic               stable_valid_q, stable_valid_d;
    logic               new_result_q, new_result_d;
    logic [CNT_W-1:0]   vote_count_q, vote_count_d;
    logic               dropped_q, dropped_d;
    logic               stale_q, stale_d;
    logic [TO_W-1:0]    idle_cnt_q, idle_cnt_d;

    logic               ready_rise;
    logic               accept;
    logic               consume;
    logic [DIGIT_W-1:0] hist_rd_digit;
    logic               hist_rd_valid;

    // An edge coinciding with clear is thrown away along with everything else.
    assign ready_rise = lenet_ready & ~ready_prev_q & enable;
    assign accept     = ready_rise & is_valid_digit(lenet_digit) & ~clear;
    assign consume    = (state_q == ST_INSERT);

    vote_history #(
        .HIST_DEPTH (HIST_DEPTH),
        .IDX_W      (IDX_W)
    ) u_history (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (clear),
        .shift_en    (consume),
        .shift_digit (pending_digit_q),
        .rd_idx      (acc_idx_q),
        .rd_digit    (hist_rd_digit),
        .rd_valid    (hist_rd_valid)
    );

    always_comb begin
        state_d         = state_q;
        ready_prev_d    = lenet_ready;
        pending_d       = pending_q;
        pending_digit_d = pending_digit_q;
        acc_idx_d       = acc_idx_q;
        sel_idx_d       = sel_idx_q;
        counts_d        = counts_q;
        winner_d        = winner_q;
        win_cnt_d       = win_cnt_q;
        stable_digit_d  = stable_digit_q;
        stable_valid_d  = stable_valid_q;
        new_result_d    = 1'b0;
        vote_count_d    = vote_count_q;
        dropped_d       = 1'b0;
        stale_d         = stale_q;
        idle_cnt_d      = idle_cnt_q;

        // One-deep pending slot. INSERT empties it in the same cycle, so a
        // result arriving then simply refills it without counting as a drop.
        if (accept) begin
            pending_d       = 1'b1;
            pending_digit_d = lenet_digit;
            if (pending_q && !consume) begin
                dropped_d = 1'b1;
            end
        end else if (consume) begin
            pending_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (pending_q) begin
                    state_d = ST_INSERT;
                end
            end
            ST_INSERT: begin
                for (int i = 0; i < NUM_CLASSES; i++) begin
                    counts_d[i] = '0;
                end
                acc_idx_d = '0;
                state_d   = ST_ACCUM;
            end
            ST_ACCUM: begin
                if (hist_rd_valid && is_valid_digit(hist_rd_digit)) begin
                    counts_d[hist_rd_digit] = counts_q[hist_rd_digit] + 1'b1;
                end
                if (acc_idx_q == IDX_W'(HIST_DEPTH - 1)) begin
                    sel_idx_d = '0;
                    winner_d  = '0;
                    win_cnt_d = '0;
                    state_d   = ST_SELECT;
                end else begin
                    acc_idx_d = acc_idx_q + 1'b1;
                end
            end
            ST_SELECT: begin
                // Strictly greater keeps the lowest digit on a tie.
                if (counts_q[sel_idx_q] > win_cnt_q) begin
                    winner_d  = sel_idx_q;
                    win_cnt_d = counts_q[sel_idx_q];
                end
                if (sel_idx_q == DIGIT_W'(NUM_CLASSES - 1)) begin
                    state_d = ST_COMMIT;
                end else begin
                    sel_idx_d = sel_idx_q + 1'b1;
                end
            end
            ST_COMMIT: begin
                vote_count_d = win_cnt_q;
                if (win_cnt_q >= CNT_W'(MIN_VOTES)) begin
                    stable_valid_d = 1'b1;
                    stable_digit_d = winner_q;
                    new_result_d   = !stable_valid_q || (stable_digit_q != winner_q);
                end else begin
                    stable_valid_d = 1'b0;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Idle timer: saturates at the timeout; stale overrides any commit.
        if (accept) begin
            idle_cnt_d = '0;
            stale_d    = 1'b0;
        end else begin
            if (idle_cnt_q != TIMEOUT_V) begin
                idle_cnt_d = idle_cnt_q + 1'b1;
            end
            stale_d = (idle_cnt_d == TIMEOUT_V);
        end
        if (stale_d) begin
            stable_valid_d = 1'b0;
            new_result_d   = 1'b0;
        end

        if (clear) begin
            state_d        = ST_IDLE;
            pending_d      = 1'b0;
            dropped_d      = 1'b0;
            for (int i = 0; i < NUM_CLASSES; i++) begin
                counts_d[i] = '0;
            end
            stable_valid_d = 1'b0;
            new_result_d   = 1'b0;
            stale_d        = 1'b0;
            idle_cnt_d     = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            // Starts high so a ready level held through reset is not an edge.
            ready_prev_q    <= 1'b1;
            pending_q       <= 1'b0;
            pending_digit_q <= '0;
            acc_idx_q       <= '0;
            sel_idx_q       <= '0;
            for (int i = 0; i < NUM_CLASSES; i++) begin
                counts_q[i] <= '0;
            end
            winner_q        <= '0;
            win_cnt_q       <= '0;
            stable_digit_q  <= '0;
            stable_valid_q  <= 1'b0;
            new_result_q    <= 1'b0;
            vote_count_q    <= '0;
            dropped_q       <= 1'b0;
            stale_q         <= 1'b0;
            idle_cnt_q      <= '0;
        end else begin
            state_q         <= state_d;
            ready_prev_q    <= ready_prev_d;
            pending_q       <= pending_d;
            pending_digit_q <= pending_digit_d;
            acc_idx_q       <= acc_idx_d;
            sel_idx_q       <= sel_idx_d;
            counts_q        <= counts_d;
            winner_q        <= winner_d;
            win_cnt_q       <= win_cnt_d;
            stable_digit_q  <= stable_digit_d;
            stable_valid_q  <= stable_valid_d;
            new_result_q    <= new_result_d;
            vote_count_q    <= vote_count_d;
            dropped_q       <= dropped_d;
            stale_q         <= stale_d;
            idle_cnt_q      <= idle_cnt_d;
        end
    end

    assign stable_digit = stable_digit_q;
    assign stable_valid = stable_valid_q;
    assign new_result   = new_result_q;
    assign vote_count   = vote_count_q;
    assign dropped      = dropped_q;

    always_comb begin
        LED                 = '0;
        LED[DIGIT_W-1:0]    = stable_digit_q;
        LED[LED_VALID_BIT]  = stable_valid_q;
        LED[LED_STALE_BIT]  = stale_q;
        LED[LED_BUSY_BIT]   = (state_q != ST_IDLE);
        LED[LED_ENABLE_BIT] = enable;
    end

endmodule

// File: tb/tb_digit_vote_filter.sv
// tb/tb_digit_vote_filter.sv - self-checking bench for digit_vote_filter
module tb_digit_vote_filter;

    localparam int H  = 8;
    localparam int MV = 5;
    localparam int TO = 1000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       lenet_ready;
    logic [3:0] lenet_digit;
    logic       enable;
    logic       clear;
    logic [3:0] stable_digit;
    logic       stable_valid;
    logic       new_result;
    logic [4:0] vote_count;
    logic       dropped;
    logic [7:0] LED;

    digit_vote_filter #(
        .HIST_DEPTH  (H),
        .MIN_VOTES   (MV),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .lenet_ready  (lenet_ready),
        .lenet_digit  (lenet_digit),
        .enable       (enable),
        .clear        (clear),
        .stable_digit (stable_digit),
        .stable_valid (stable_valid),
        .new_result   (new_result),
        .vote_count   (vote_count),
        .dropped      (dropped),
        .LED          (LED)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int nr_cnt = 0;
    int nr_last = 0;
    int drop_cnt = 0;
    int det_cyc = 0;
    int checks = 0;
    int failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (new_result === 1'b1) begin
            nr_cnt  <= nr_cnt + 1;
            nr_last <= cyc;
        end
        if (dropped === 1'b1) drop_cnt <= drop_cnt + 1;
    end

    typedef struct {
        logic [3:0] d;
        logic [3:0] exp_digit;
        logic       exp_valid;
        logic [4:0] exp_cnt;
        int         exp_new;
    } vec_t;

    vec_t tbl[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic send(input logic [3:0] d);
        @(negedge clk);
        lenet_ready = 1'b1;
        lenet_digit = d;
        @(posedge clk);
        #1 det_cyc = cyc;
        repeat (3) @(negedge clk);
        lenet_ready = 1'b0;
    endtask

    task automatic pulse(input logic [3:0] d);
        @(negedge clk);
        lenet_ready = 1'b1;
        lenet_digit = d;
        @(negedge clk);
        lenet_ready = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        @(negedge clk);
        while (LED[6] !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(name, LED[6], 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nr0;
        int dr0;
        int last_det;

        tbl[0]  = '{4'd3, 4'd0, 1'b0, 5'd1, 0};
        tbl[1]  = '{4'd3, 4'd0, 1'b0, 5'd2, 0};
        tbl[2]  = '{4'd3, 4'd0, 1'b0, 5'd3, 0};
        tbl[3]  = '{4'd3, 4'd0, 1'b0, 5'd4, 0};
        tbl[4]  = '{4'd3, 4'd3, 1'b1, 5'd5, 1};
        tbl[5]  = '{4'd7, 4'd3, 1'b1, 5'd5, 0};
        tbl[6]  = '{4'd7, 4'd3, 1'b1, 5'd5, 0};
        tbl[7]  = '{4'd7, 4'd3, 1'b1, 5'd5, 0};
        tbl[8]  = '{4'd7, 4'd3, 1'b0, 5'd4, 0};
        tbl[9]  = '{4'd2, 4'd3, 1'b0, 5'd4, 0};
        tbl[10] = '{4'd2, 4'd3, 1'b0, 5'd4, 0};
        tbl[11] = '{4'd2, 4'd3, 1'b0, 5'd4, 0};
        tbl[12] = '{4'd2, 4'd3, 1'b0, 5'd4, 0};
        tbl[13] = '{4'd2, 4'd2, 1'b1, 5'd5, 1};

        rst_n       = 1'b0;
        lenet_ready = 1'b1;
        lenet_digit = 4'd0;
        enable      = 1'b0;
        clear       = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_stable_digit", stable_digit, 0);
        check("rst_stable_valid", stable_valid, 0);
        check("rst_vote_count", vote_count, 0);
        check("rst_led", LED, 0);
        check("rst_new_result", new_result, 0);
        check("rst_dropped", dropped, 0);

        rst_n  = 1'b1;
        enable = 1'b1;
        repeat (5) @(negedge clk);
        check("ready_high_out_of_reset_busy", LED[6], 0);
        lenet_ready = 1'b0;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 14; i++) begin
            nr0 = nr_cnt;
            send(tbl[i].d);
            wait_idle($sformatf("row%0d_done", i));
            check($sformatf("row%0d_stable_digit", i), stable_digit, tbl[i].exp_digit);
            check($sformatf("row%0d_stable_valid", i), stable_valid, tbl[i].exp_valid);
            check($sformatf("row%0d_vote_count", i), vote_count, tbl[i].exp_cnt);
            check($sformatf("row%0d_new_pulses", i), nr_cnt - nr0, tbl[i].exp_new);
            if (tbl[i].exp_new == 1)
                check($sformatf("row%0d_latency", i), nr_last - det_cyc, H + 13);
            repeat (60) @(negedge clk);
        end
        last_det = det_cyc;

        // Out-of-range digit midway through the idle window.
        wait_until(last_det + 600);
        send(4'd12);
        repeat (4) @(negedge clk);
        check("bad_digit_busy", LED[6], 0);
        check("bad_digit_vote_count", vote_count, 5);
        wait_until(last_det + 990);
        check("pre_timeout_stale", LED[5], 0);
        check("pre_timeout_valid", stable_valid, 1);
        wait_until(last_det + 1005);
        check("timeout_stale", LED[5], 1);
        check("timeout_valid", stable_valid, 0);

        nr0 = nr_cnt;
        send(4'd2);
        check("stale_cleared", LED[5], 0);
        wait_idle("after_stale_done");
        check("after_stale_valid", stable_valid, 1);
        check("after_stale_digit", stable_digit, 2);
        check("after_stale_count", vote_count, 6);
        check("after_stale_new", nr_cnt - nr0, 1);

        enable = 1'b0;
        send(4'd5);
        repeat (4) @(negedge clk);
        check("disabled_busy", LED[6], 0);
        check("disabled_led7", LED[7], 0);
        enable = 1'b1;
        repeat (3) @(negedge clk);

        @(negedge clk) clear = 1'b1;
        @(negedge clk) clear = 1'b0;
        check("clear_valid", stable_valid, 0);
        for (int i = 0; i < 5; i++) begin
            send(4'd5);
            wait_idle("fives_done");
        end
        check("fives_valid", stable_valid, 1);
        check("fives_digit", stable_digit, 5);
        check("fives_count", vote_count, 5);

        send(4'd5);
        check("mid_accum_busy", LED[6], 1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clear_mid_busy", LED[6], 0);
        check("clear_mid_valid", stable_valid, 0);
        check("clear_mid_stale", LED[5], 0);
        nr0 = nr_cnt;
        send(4'd6);
        wait_idle("single_done");
        check("single_count", vote_count, 1);
        check("single_valid", stable_valid, 0);
        check("single_digit_held", stable_digit, 5);
        check("single_new", nr_cnt - nr0, 0);

        @(negedge clk) clear = 1'b1;
        @(negedge clk) clear = 1'b0;
        dr0 = drop_cnt;
        pulse(4'd4);
        @(negedge clk);
        pulse(4'd4);
        @(negedge clk);
        pulse(4'd6);
        repeat (60) @(negedge clk);
        check("overwrite_drop_pulses", drop_cnt - dr0, 1);
        check("overwrite_vote_count", vote_count, 1);
        check("overwrite_busy", LED[6], 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
